// File: rtl/mac_pkt_fifo.sv
// mac_pkt_fifo: store-and-forward packet buffer between a MAC receive stream and a
// valid/ready transmit port. A packet becomes visible on tx only after its eop word
// has been written. Overflowing or badly framed packets are dropped without
// touching packets that are already committed.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   rx_data/valid/sop/eop/bv     receive stream (no backpressure)
//   tx_data/valid/sop/eop/bv     transmit word, held while tx_valid & !tx_ready
//   tx_ready                     downstream accept
//   pkt_count                    committed packets not yet fully read
//   drop                         one-cycle pulse per dropped packet or fragment
//   stat_pkts_in/stat_pkts_drop  saturating 16-bit counters, present only when
//                                MAC_PKT_FIFO_STATS_EN is defined
module mac_pkt_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned BV_W   = $clog2(DATA_W / 8)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         rx_data,
  input  logic                      rx_valid,
  input  logic                      rx_sop,
  input  logic                      rx_eop,
  input  logic [BV_W-1:0]           rx_bv,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      tx_sop,
  output logic                      tx_eop,
  output logic [BV_W-1:0]           tx_bv,
  output logic [$clog2(DEPTH):0]    pkt_count,
  output logic                      drop
`ifdef MAC_PKT_FIFO_STATS_EN
  ,
  output logic [15:0]               stat_pkts_in,
  output logic [15:0]               stat_pkts_drop
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = 2 + BV_W + DATA_W;

  typedef logic [PW-1:0] ptr_t;
  typedef enum logic [1:0] {StIdle, StWrite, StDiscard} wr_state_e;

  logic [EW-1:0] mem_q [DEPTH];

  wr_state_e   state_q, state_d;
  ptr_t        wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q;
  ptr_t        wr_addr;
  logic        we, commit, drop_d, drop_q;
  logic        full, full_c, load, fire_eop;
  logic        tx_valid_q;
  logic [EW-1:0] tx_entry_q;
  logic [PW-1:0] pkt_count_q;

  // Uncommitted words count toward full; full_c only counts committed words and is
  // used when a restart on sop has already rewound the write pointer.
  assign full   = (wr_ptr_q - rd_ptr_q) == ptr_t'(DEPTH);
  assign full_c = (commit_ptr_q - rd_ptr_q) == ptr_t'(DEPTH);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    wr_addr      = wr_ptr_q;
    we           = 1'b0;
    commit       = 1'b0;
    drop_d       = 1'b0;
    if (rx_valid) begin
      unique case (state_q)
        StIdle, StDiscard: begin
          // wr_ptr equals commit_ptr in both of these states.
          if (rx_sop) begin
            if (full) begin
              drop_d  = 1'b1;
              state_d = rx_eop ? StIdle : StDiscard;
            end else begin
              we       = 1'b1;
              wr_ptr_d = wr_ptr_q + 1'b1;
              if (rx_eop) begin
                commit       = 1'b1;
                commit_ptr_d = wr_ptr_q + 1'b1;
                state_d      = StIdle;
              end else begin
                state_d = StWrite;
              end
            end
          end else if (state_q == StIdle) begin
            drop_d  = 1'b1;
            state_d = rx_eop ? StIdle : StDiscard;
          end else if (rx_eop) begin
            state_d = StIdle;
          end
        end
        StWrite: begin
          if (rx_sop) begin
            // Abandon the open packet and restart at the last commit point.
            drop_d   = 1'b1;
            wr_ptr_d = commit_ptr_q;
            wr_addr  = commit_ptr_q;
            if (full_c) begin
              state_d = rx_eop ? StIdle : StDiscard;
            end else begin
              we       = 1'b1;
              wr_ptr_d = commit_ptr_q + 1'b1;
              if (rx_eop) begin
                commit       = 1'b1;
                commit_ptr_d = commit_ptr_q + 1'b1;
                state_d      = StIdle;
              end
            end
          end else if (full) begin
            drop_d   = 1'b1;
            wr_ptr_d = commit_ptr_q;
            state_d  = rx_eop ? StIdle : StDiscard;
          end else begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (rx_eop) begin
              commit       = 1'b1;
              commit_ptr_d = wr_ptr_q + 1'b1;
              state_d      = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign load     = (!tx_valid_q || tx_ready) && (rd_ptr_q != commit_ptr_q);
  assign fire_eop = tx_valid_q && tx_ready && tx_entry_q[EW-2];

  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem_q[wr_addr[AW-1:0]] <= {rx_sop, rx_eop, rx_bv, rx_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      drop_q       <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_entry_q   <= '0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      drop_q       <= drop_d;
      if (load) begin
        tx_entry_q <= mem_q[rd_ptr_q[AW-1:0]];
        tx_valid_q <= 1'b1;
        rd_ptr_q   <= rd_ptr_q + 1'b1;
      end else if (tx_ready) begin
        tx_valid_q <= 1'b0;
      end
      unique case ({commit, fire_eop})
        2'b10:   pkt_count_q <= pkt_count_q + 1'b1;
        2'b01:   pkt_count_q <= pkt_count_q - 1'b1;
        default: pkt_count_q <= pkt_count_q;
      endcase
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_sop    = tx_entry_q[EW-1];
  assign tx_eop    = tx_entry_q[EW-2];
  assign tx_bv     = tx_entry_q[DATA_W +: BV_W];
  assign tx_data   = tx_entry_q[DATA_W-1:0];
  assign pkt_count = pkt_count_q;
  assign drop      = drop_q;

`ifdef MAC_PKT_FIFO_STATS_EN
  logic [15:0] stat_in_q, stat_drop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_in_q   <= '0;
      stat_drop_q <= '0;
    end else begin
      if (commit && stat_in_q != 16'hFFFF) stat_in_q <= stat_in_q + 1'b1;
      if (drop_d && stat_drop_q != 16'hFFFF) stat_drop_q <= stat_drop_q + 1'b1;
    end
  end

  assign stat_pkts_in   = stat_in_q;
  assign stat_pkts_drop = stat_drop_q;
`endif

endmodule
